// File: rtl/rx_bd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bd_pkg
//  Description : Shared types and constants for the Rx boundary detector:
//                FSM state encoding, modulation mode values and the lane
//                break helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rx_bd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } bd_state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    // A break is a repeat on every lane in use; in QPSK a single-lane
    // repeat is neither alternation nor a break.
    function automatic logic lane_break(input logic mode, input logic rep_i, input logic rep_q);
        return (mode == MODE_QPSK) ? (rep_i & rep_q) : rep_i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bd_alt_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bd_alt_tracker
//  Description : Holds the previous I/Q hard decisions, flags symbol repeats,
//                derives the break condition and counts the current run of
//                alternating symbols (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module rx_bd_alt_tracker
    import rx_bd_pkg::*;
#(
    parameter int RUN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clk_enable,
    input  logic                 i_mode,
    input  logic                 i_sym_i,
    input  logic                 i_sym_q,
    input  logic                 i_clear_run,
    output logic                 o_any_rep,
    output logic                 o_brk,
    output logic [RUN_WIDTH-1:0] o_alt_run
);

    logic                 r_i_reg;
    logic                 r_q_reg;
    logic [RUN_WIDTH-1:0] r_alt_run;
    logic                 w_rep_i;
    logic                 w_rep_q;
    logic                 w_any_rep;

    assign w_rep_i   = ~(i_sym_i ^ r_i_reg);
    assign w_rep_q   = ~(i_sym_q ^ r_q_reg);
    // Q lane only participates in QPSK.
    assign w_any_rep = w_rep_i | ((i_mode == MODE_QPSK) & w_rep_q);

    assign o_any_rep = w_any_rep;
    assign o_brk     = lane_break(i_mode, w_rep_i, w_rep_q);
    assign o_alt_run = r_alt_run;

    // Lane history and saturating alternation run, advanced on symbol strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_reg   <= 1'b0;
            r_q_reg   <= 1'b0;
            r_alt_run <= '0;
        end else if (i_clk_enable) begin
            r_i_reg <= i_sym_i;
            r_q_reg <= i_sym_q;
            if (i_clear_run || w_any_rep) begin
                r_alt_run <= '0;
            end else if (r_alt_run != '1) begin
                r_alt_run <= r_alt_run + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_bd_mc.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bd_mc
//  Description : Multi-mode (BPSK/QPSK) TRN boundary detector. Finds the
//                single sign inversion in an alternating symbol stream after
//                a minimum alternation run, confirms it over a window, and
//                reports lock, break sign and search timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_bd_mc
    import rx_bd_pkg::*;
#(
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int TIMEOUT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_enable,
    input  logic                        RX_BD_MODE,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_MIN_RUN,
    input  logic [TIMEOUT_WIDTH-1:0]    RX_BD_TIMEOUT,
    input  logic                        sym_i,
    input  logic                        sym_q,
    input  logic                        PD_flag,
    input  logic                        disassert_BD,
    output logic                        BD_init,
    output logic                        BD_flag,
    output logic [1:0]                  BD_sgn,
    output logic                        BD_timeout,
    output logic [2:0]                  BD_state
);

    localparam logic [MAX_WINDOW_WIDTH-1:0] C_WIN_ONE = MAX_WINDOW_WIDTH'(1);

    bd_state_t                   r_state;
    logic [MAX_WINDOW_WIDTH-1:0] r_cnt;
    logic [TIMEOUT_WIDTH-1:0]    r_search_cnt;
    logic                        r_bd_init;
    logic                        r_bd_flag;
    logic [1:0]                  r_bd_sgn;
    logic                        r_bd_timeout;

    bd_state_t                   w_state_nxt;
    logic [MAX_WINDOW_WIDTH-1:0] w_cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0]    w_search_nxt;
    logic                        w_init_nxt;
    logic                        w_flag_nxt;
    logic [1:0]                  w_sgn_nxt;
    logic                        w_timeout_nxt;

    logic                        w_any_rep;
    logic                        w_brk;
    logic [MAX_WINDOW_WIDTH-1:0] w_alt_run;
    logic [MAX_WINDOW_WIDTH-1:0] w_win_eff;
    logic [TIMEOUT_WIDTH-1:0]    w_search_inc;
    logic                        w_timeout_hit;
    logic                        w_clear;

    rx_bd_alt_tracker #(
        .RUN_WIDTH (MAX_WINDOW_WIDTH)
    ) u_alt_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clk_enable (clk_enable),
        .i_mode       (RX_BD_MODE),
        .i_sym_i      (sym_i),
        .i_sym_q      (sym_q),
        .i_clear_run  (r_state == ST_IDLE),
        .o_any_rep    (w_any_rep),
        .o_brk        (w_brk),
        .o_alt_run    (w_alt_run)
    );

    // A zero window would lock instantly; treat it as a single symbol.
    assign w_win_eff     = (RX_BD_WINDOW == '0) ? C_WIN_ONE : RX_BD_WINDOW;
    assign w_search_inc  = r_search_cnt + 1'b1;
    assign w_timeout_hit = (RX_BD_TIMEOUT != '0) && (w_search_inc >= RX_BD_TIMEOUT);
    assign w_clear       = disassert_BD | ~PD_flag;

    // Next-state and next-output decode: clear beats timeout beats detection.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_search_nxt  = r_search_cnt;
        w_init_nxt    = r_bd_init;
        w_flag_nxt    = r_bd_flag;
        w_sgn_nxt     = r_bd_sgn;
        w_timeout_nxt = r_bd_timeout;

        if (w_clear) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_search_nxt  = '0;
            w_init_nxt    = 1'b0;
            w_flag_nxt    = 1'b0;
            w_sgn_nxt     = 2'b00;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SEARCH;
                end
                ST_SEARCH, ST_CONFIRM: begin
                    w_search_nxt = w_search_inc;
                    if (w_timeout_hit) begin
                        w_state_nxt   = ST_TIMEOUT;
                        w_cnt_nxt     = '0;
                        w_init_nxt    = 1'b0;
                        w_flag_nxt    = 1'b0;
                        w_sgn_nxt     = 2'b00;
                        w_timeout_nxt = 1'b1;
                    end else if (r_state == ST_SEARCH) begin
                        if (w_brk && (w_alt_run >= RX_BD_MIN_RUN)) begin
                            w_state_nxt = ST_CONFIRM;
                            w_init_nxt  = 1'b1;
                            w_cnt_nxt   = C_WIN_ONE;
                            w_sgn_nxt   = {RX_BD_MODE & sym_q, sym_i};
                        end
                    end else if (w_any_rep) begin
                        // False break inside the window: restart the search.
                        w_state_nxt = ST_SEARCH;
                        w_init_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_sgn_nxt   = 2'b00;
                    end else if (r_cnt >= w_win_eff) begin
                        w_state_nxt = ST_LOCKED;
                        w_flag_nxt  = 1'b1;
                        w_init_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_LOCKED, ST_TIMEOUT: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and output registers advance only on symbol strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_search_cnt <= '0;
            r_bd_init    <= 1'b0;
            r_bd_flag    <= 1'b0;
            r_bd_sgn     <= 2'b00;
            r_bd_timeout <= 1'b0;
        end else if (clk_enable) begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_search_cnt <= w_search_nxt;
            r_bd_init    <= w_init_nxt;
            r_bd_flag    <= w_flag_nxt;
            r_bd_sgn     <= w_sgn_nxt;
            r_bd_timeout <= w_timeout_nxt;
        end
    end

    assign BD_init    = r_bd_init;
    assign BD_flag    = r_bd_flag;
    assign BD_sgn     = r_bd_sgn;
    assign BD_timeout = r_bd_timeout;
    assign BD_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rx_bd_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_bd_mc
//  Description : Self-checking bench for rx_bd_mc with directed scenarios and
//                randomized traffic against a behavioural boundary model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_bd_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic        cfg_mode;
    logic [7:0]  cfg_window;
    logic [7:0]  cfg_min_run;
    logic [15:0] cfg_timeout;
    logic        sym_i, sym_q, PD_flag, disassert_BD;
    logic        BD_init, BD_flag, BD_timeout;
    logic [1:0]  BD_sgn;
    logic [2:0]  BD_state;
    logic [7:0]  dut_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model: phase 0 idle, 1 search, 2 confirm, 3 locked, 4 timeout.
    int          m_phase, m_run, m_clean, m_elapsed;
    logic        m_prev_i, m_prev_q, m_init, m_flag, m_to;
    logic [1:0]  m_sgn;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_bd_mc #(.MAX_WINDOW_WIDTH(8), .TIMEOUT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_enable    (clk_enable),
        .RX_BD_MODE    (cfg_mode),
        .RX_BD_WINDOW  (cfg_window),
        .RX_BD_MIN_RUN (cfg_min_run),
        .RX_BD_TIMEOUT (cfg_timeout),
        .sym_i         (sym_i),
        .sym_q         (sym_q),
        .PD_flag       (PD_flag),
        .disassert_BD  (disassert_BD),
        .BD_init       (BD_init),
        .BD_flag       (BD_flag),
        .BD_sgn        (BD_sgn),
        .BD_timeout    (BD_timeout),
        .BD_state      (BD_state)
    );

    assign dut_vec = {BD_state, BD_init, BD_flag, BD_sgn, BD_timeout};

    function automatic logic [7:0] exp_vec();
        return {3'(m_phase), m_init, m_flag, m_sgn, m_to};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_run = 0; m_clean = 0; m_elapsed = 0;
        m_prev_i = 1'b0; m_prev_q = 1'b0;
        m_init = 1'b0; m_flag = 1'b0; m_to = 1'b0; m_sgn = 2'b00;
    endtask

    // One accepted symbol, following the detector rules directly.
    task automatic model_clock(input logic si, input logic sq, input logic pd, input logic dis);
        logic rep_i, rep_q, used_rep, brk;
        int   run_before, was_idle, weff;
        rep_i      = (si == m_prev_i);
        rep_q      = (sq == m_prev_q);
        used_rep   = rep_i || (cfg_mode && rep_q);
        brk        = cfg_mode ? (rep_i && rep_q) : rep_i;
        run_before = m_run;
        was_idle   = (m_phase == 0);
        weff       = (cfg_window == 0) ? 1 : int'(cfg_window);
        if (dis || !pd) begin
            m_phase = 0; m_init = 0; m_flag = 0; m_sgn = 0; m_to = 0;
            m_elapsed = 0; m_clean = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            m_elapsed++;
            if (cfg_timeout != 0 && m_elapsed >= int'(cfg_timeout)) begin
                m_phase = 4; m_to = 1; m_flag = 0; m_init = 0; m_sgn = 0;
            end else if (m_phase == 1) begin
                if (brk && run_before >= int'(cfg_min_run)) begin
                    m_phase = 2; m_init = 1; m_clean = 0;
                    m_sgn = {cfg_mode & sq, si};
                end
            end else if (used_rep) begin
                m_phase = 1; m_init = 0; m_sgn = 0;
            end else begin
                m_clean++;
                if (m_clean >= weff) begin
                    m_phase = 3; m_flag = 1; m_init = 0;
                end
            end
        end
        if (was_idle || used_rep) m_run = 0;
        else if (m_run < 255) m_run++;
        m_prev_i = si;
        m_prev_q = sq;
    endtask

    // Drive on the falling edge, let the rising edge act, settle 1 unit after.
    task automatic step(input logic si, input logic sq, input logic pd, input logic dis, input logic en);
        @(negedge clk);
        sym_i = si; sym_q = sq; PD_flag = pd; disassert_BD = dis; clk_enable = en;
        @(posedge clk);
        if (en && rst_n) model_clock(si, sq, pd, dis);
        #1;
    endtask

    task automatic go_idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_cfg(input logic mode, input int win, input int mr, input int to);
        cfg_mode = mode; cfg_window = 8'(win); cfg_min_run = 8'(mr); cfg_timeout = 16'(to);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_enable = 1'b0; sym_i = 0; sym_q = 0; PD_flag = 0; disassert_BD = 0;
        set_cfg(1'b0, 4, 6, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 8'h00); end
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== {3'd1, 5'b0}) begin errors++; $display("FAIL idle_to_search: got %h expected %h", dut_vec, {3'd1, 5'b0}); end
    endtask

    task automatic test_bpsk_lock();
        logic s;
        set_cfg(1'b0, 4, 6, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(s, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bpsk_alt: got %h expected %h", dut_vec, exp_vec()); end
            s = ~s;
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_state, BD_init, BD_sgn} !== {3'd2, 1'b1, 2'b01}) begin
            errors++; $display("FAIL bpsk_break: got %h expected %h", {BD_state, BD_init, BD_sgn}, {3'd2, 1'b1, 2'b01});
        end
        s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(s, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bpsk_confirm: got %h expected %h", dut_vec, exp_vec()); end
            checks++;
            if (BD_flag !== (k == 3)) begin errors++; $display("FAIL bpsk_lock_latency: got %b expected %b at %0d", BD_flag, (k == 3), k); end
            s = ~s;
        end
        checks++;
        if ({BD_init, BD_sgn} !== 3'b001) begin errors++; $display("FAIL bpsk_locked_sgn: got %b expected %b", {BD_init, BD_sgn}, 3'b001); end
    endtask

    task automatic test_unqualified();
        logic s;
        set_cfg(1'b0, 4, 6, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 0; k < 3; k++) begin step(s, 1'b0, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_state, BD_init} !== {3'd1, 1'b0}) begin errors++; $display("FAIL short_run_ignored: got %h expected %h", {BD_state, BD_init}, {3'd1, 1'b0}); end
        s = 1'b0;
        for (int k = 0; k < 8; k++) begin step(s, 1'b0, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_init, BD_sgn} !== 3'b101) begin errors++; $display("FAIL second_break: got %b expected %b", {BD_init, BD_sgn}, 3'b101); end
        s = 1'b0;
        for (int k = 0; k < 4; k++) begin step(s, 1'b0, 1'b1, 1'b0, 1'b1); s = ~s; end
        checks++;
        if (dut_vec !== {3'd3, 1'b0, 1'b1, 2'b01, 1'b0}) begin
            errors++; $display("FAIL second_break_lock: got %h expected %h", dut_vec, {3'd3, 1'b0, 1'b1, 2'b01, 1'b0});
        end
    endtask

    task automatic test_false_break();
        logic s;
        set_cfg(1'b0, 4, 6, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 0; k < 7; k++) begin step(s, 1'b0, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== {3'd1, 5'b0}) begin errors++; $display("FAIL false_break_abort: got %h expected %h", dut_vec, {3'd1, 5'b0}); end
        s = 1'b1;
        for (int k = 0; k < 8; k++) begin step(s, 1'b0, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(s, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL false_break_relock: got %h expected %h", dut_vec, exp_vec()); end
            s = ~s;
        end
        checks++;
        if ({BD_flag, BD_sgn} !== 3'b100) begin errors++; $display("FAIL relock_sgn: got %b expected %b", {BD_flag, BD_sgn}, 3'b100); end
    endtask

    task automatic test_qpsk();
        logic s;
        set_cfg(1'b1, 3, 4, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 0; k < 5; k++) begin step(s, s, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_state, BD_init} !== {3'd1, 1'b0}) begin errors++; $display("FAIL qpsk_single_lane: got %h expected %h", {BD_state, BD_init}, {3'd1, 1'b0}); end
        s = 1'b0;
        for (int k = 0; k < 5; k++) begin step(s, ~s, 1'b1, 1'b0, 1'b1); s = ~s; end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_init, BD_sgn} !== 3'b110) begin errors++; $display("FAIL qpsk_break_sgn: got %b expected %b", {BD_init, BD_sgn}, 3'b110); end
        s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(s, ~s, 1'b1, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL qpsk_confirm: got %h expected %h", dut_vec, exp_vec()); end
            s = ~s;
        end
        checks++;
        if ({BD_flag, BD_sgn} !== 3'b110) begin errors++; $display("FAIL qpsk_lock: got %b expected %b", {BD_flag, BD_sgn}, 3'b110); end
    endtask

    task automatic test_timeout();
        logic s;
        set_cfg(1'b0, 4, 6, 20);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(s, 1'b0, 1'b1, 1'b0, 1'b1);
            s = ~s;
            if (k == 19) begin
                checks++;
                if ({BD_state, BD_timeout} !== {3'd1, 1'b0}) begin errors++; $display("FAIL timeout_early: got %h expected %h", {BD_state, BD_timeout}, {3'd1, 1'b0}); end
            end
        end
        checks++;
        if (dut_vec !== {3'd4, 4'b0, 1'b1}) begin errors++; $display("FAIL timeout_hit: got %h expected %h", dut_vec, {3'd4, 4'b0, 1'b1}); end
        step(s, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (BD_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", BD_timeout); end
        go_idle();
        checks++;
        if (dut_vec !== 8'h00) begin errors++; $display("FAIL timeout_clear: got %h expected %h", dut_vec, 8'h00); end
    endtask

    task automatic test_async_reset();
        set_cfg(1'b0, 4, 2, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_state, BD_init} !== {3'd2, 1'b1}) begin errors++; $display("FAIL async_setup: got %h expected %h", {BD_state, BD_init}, {3'd2, 1'b1}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 8'h00) begin errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, 8'h00); end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL after_async: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_enable_stall();
        int   t_init, t_flag;
        logic [4:0] stall_syms;
        stall_syms = 5'b01010;
        set_cfg(1'b0, 4, 2, 0);
        go_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        t_init = cyc;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 4; k >= 0; k--) begin
            step(stall_syms[k], 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL stall_frozen: got %h expected %h", dut_vec, exp_vec()); end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({BD_state, BD_flag} !== {3'd2, 1'b0}) begin errors++; $display("FAIL stall_resume: got %h expected %h", {BD_state, BD_flag}, {3'd2, 1'b0}); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        t_flag = cyc;
        checks++;
        if (BD_flag !== 1'b1 || (t_flag - t_init) !== 9) begin
            errors++; $display("FAIL stall_latency: got flag=%b cycles=%0d expected flag=1 cycles=9", BD_flag, t_flag - t_init);
        end
    endtask

    task automatic test_random();
        logic di, dq, pd, dis, en;
        int   r;
        di = 1'b0; dq = 1'b0;
        for (int seg = 0; seg < 12; seg++) begin
            go_idle();
            di = 1'b0; dq = 1'b0;
            set_cfg(1'($urandom % 2), int'($urandom % 6), int'($urandom % 9),
                    ($urandom % 3 == 0) ? 0 : 15 + int'($urandom % 60));
            for (int k = 0; k < 60; k++) begin
                r   = int'($urandom % 24);
                pd  = (r != 0);
                dis = (r == 1);
                en  = ($urandom % 5 != 0);
                if ($urandom % 8 != 0) di = ~di;
                if ($urandom % 8 != 0) dq = ~dq;
                step(di, dq, pd, dis, en);
                checks++;
                if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random seg%0d cyc%0d: got %h expected %h", seg, k, dut_vec, exp_vec()); end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bpsk_lock();
        test_unqualified();
        test_false_break();
        test_qpsk();
        test_timeout();
        test_async_reset();
        test_enable_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
